// File: rtl/uart_fifo_port_if.sv
// CPU-side byte handshake of the UART port.
//   master : the data path, which pushes tx bytes and pops rx bytes
//   slave  : the UART, which reports tx busy and the rx head/valid
// tx_data_in/tx_we_in : byte + single-cycle push strobe into the TX FIFO
// tx_busy_out         : TX FIFO full
// rx_data_out/valid   : RX FIFO head (first-word-fall-through), non-empty
// rx_re_in            : single-cycle pop strobe from the RX FIFO
interface uart_fifo_port_if;
  logic [7:0] tx_data_in;
  logic       tx_we_in;
  logic       tx_busy_out;
  logic [7:0] rx_data_out;
  logic       rx_valid_out;
  logic       rx_re_in;

  modport master (output tx_data_in, tx_we_in, rx_re_in,
                  input  tx_busy_out, rx_data_out, rx_valid_out);
  modport slave  (input  tx_data_in, tx_we_in, rx_re_in,
                  output tx_busy_out, rx_data_out, rx_valid_out);
endinterface

// File: rtl/uart_fifo_port.sv
// 8N1 UART peripheral with TX/RX FIFOs and a 16x oversampling baud tick.
// Ports:
//   clk, rst          : system clock, asynchronous active-low reset
//   bus (slave)       : byte handshake to the data path (see uart_fifo_port_if)
//   rxd / txd         : serial in (asynchronous) / serial out (idle high)
//   tx_level/rx_level : FIFO occupancies, 0..FIFO_DEPTH
//   rx_overrun        : sticky, a received byte was dropped (RX FIFO full)
//   rx_frame_err      : sticky, a stop bit was sampled low
//   clr_err_in        : clears both sticky flags (a same-cycle set wins)
module uart_fifo_port #(
  parameter  int CLK_HZ     = 100000000,
  parameter  int BAUD       = 115200,
  parameter  int FIFO_DEPTH = 16,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_fifo_port_if.slave      bus,
  input  logic                 rxd,
  output logic                 txd,
  output logic [LW-1:0]        tx_level,
  output logic [LW-1:0]        rx_level,
  output logic                 rx_overrun,
  output logic                 rx_frame_err,
  input  logic                 clr_err_in
);
  localparam int DIV_T = CLK_HZ / (16 * BAUD);
  localparam int DIV   = (DIV_T < 1) ? 1 : DIV_T;
  localparam int CW    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} st_t;

  // ---------------- baud tick ----------------
  logic [CW-1:0] div_cnt;
  logic          tick;
  assign tick = (div_cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst)
    if (!rst) div_cnt <= '0;
    else      div_cnt <= tick ? '0 : div_cnt + 1'b1;

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic          tx_push, tx_pop;
  st_t           tx_st;
  logic [3:0]    tx_tc;
  logic [2:0]    tx_bi;
  logic [7:0]    tx_sh;

  assign tx_push         = bus.tx_we_in && (tx_level != FULL);
  // Pop from IDLE, or straight out of the last stop tick so back-to-back
  // bytes leave no gap on the line.
  assign tx_pop          = tick && (tx_level != '0) &&
                           ((tx_st == IDLE) || ((tx_st == STOP) && (tx_tc == 4'd15)));
  assign bus.tx_busy_out = (tx_level == FULL);

  always_ff @(posedge clk)
    if (tx_push) tx_mem[tx_wp] <= bus.tx_data_in;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + 1'b1;
        2'b01:   tx_level <= tx_level - 1'b1;
        default: ;
      endcase
    end

  // ---------------- TX FSM ----------------
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      tx_st <= IDLE; tx_tc <= '0; tx_bi <= '0; tx_sh <= '0; txd <= 1'b1;
    end else if (tick) begin
      case (tx_st)
        IDLE:
          if (tx_pop) begin
            tx_sh <= tx_mem[tx_rp]; txd <= 1'b0; tx_tc <= '0; tx_st <= START;
          end
        START: begin
          tx_tc <= tx_tc + 1'b1;
          if (tx_tc == 4'd15) begin
            tx_st <= DATA; tx_bi <= '0; txd <= tx_sh[0];
          end
        end
        DATA: begin
          tx_tc <= tx_tc + 1'b1;
          if (tx_tc == 4'd15) begin
            if (tx_bi == 3'd7) begin
              tx_st <= STOP; txd <= 1'b1;
            end else begin
              tx_bi <= tx_bi + 1'b1; txd <= tx_sh[1]; tx_sh <= tx_sh >> 1;
            end
          end
        end
        STOP: begin
          tx_tc <= tx_tc + 1'b1;
          if (tx_tc == 4'd15) begin
            if (tx_pop) begin
              tx_sh <= tx_mem[tx_rp]; txd <= 1'b0; tx_st <= START;
            end else begin
              tx_st <= IDLE;
            end
          end
        end
        default: tx_st <= IDLE;
      endcase
    end

  // ---------------- RX synchronizer + FSM ----------------
  logic [1:0] rx_sync;
  logic       rs;
  st_t        rx_st;
  logic [3:0] rx_tc;
  logic [2:0] rx_bi;
  logic [7:0] rx_sh;
  logic       stop_smp, rx_push, rx_pop;
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;

  assign rs       = rx_sync[1];
  assign stop_smp = tick && (rx_st == STOP) && (rx_tc == 4'd15);
  assign rx_push  = stop_smp && rs && (rx_level != FULL);
  assign rx_pop   = bus.rx_re_in && (rx_level != '0);

  always_ff @(posedge clk or negedge rst)
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rxd};

  // START samples 8 ticks after the edge is seen; every later sample is
  // 16 ticks on, so all bits are read near their middle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_st <= IDLE; rx_tc <= '0; rx_bi <= '0; rx_sh <= '0;
    end else if (tick) begin
      case (rx_st)
        IDLE:
          if (!rs) begin
            rx_st <= START; rx_tc <= '0;
          end
        START:
          if (rx_tc == 4'd7) begin
            rx_st <= rs ? IDLE : DATA;  // high at mid-start: glitch
            rx_tc <= '0; rx_bi <= '0;
          end else begin
            rx_tc <= rx_tc + 1'b1;
          end
        DATA: begin
          rx_tc <= rx_tc + 1'b1;
          if (rx_tc == 4'd15) begin
            rx_sh <= {rs, rx_sh[7:1]};
            if (rx_bi == 3'd7) rx_st <= STOP;
            else               rx_bi <= rx_bi + 1'b1;
          end
        end
        STOP: begin
          rx_tc <= rx_tc + 1'b1;
          if (rx_tc == 4'd15) rx_st <= IDLE;
        end
        default: rx_st <= IDLE;
      endcase
    end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_overrun <= 1'b0; rx_frame_err <= 1'b0;
    end else begin
      rx_overrun   <= (stop_smp && rs && (rx_level == FULL)) | (rx_overrun & ~clr_err_in);
      rx_frame_err <= (stop_smp && !rs) | (rx_frame_err & ~clr_err_in);
    end

  // ---------------- RX FIFO ----------------
  always_ff @(posedge clk)
    if (rx_push) rx_mem[rx_wp] <= rx_sh;

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rx_wp <= '0; rx_rp <= '0; rx_level <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + 1'b1;
        2'b01:   rx_level <= rx_level - 1'b1;
        default: ;
      endcase
    end

  assign bus.rx_valid_out = (rx_level != '0);
  assign bus.rx_data_out  = (rx_level != '0) ? rx_mem[rx_rp] : 8'h00;
endmodule

// File: tb/tb_uart_fifo_port.sv
module tb_uart_fifo_port;
  localparam int CLK_HZ = 1600000, BAUD = 10000, DEPTH = 16, LW = 5;
  localparam int BITC = 160;  // clocks per bit with DIV = 10

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, rxd, txd, loop, tb_rxd, clr_err;
  logic [LW-1:0] tx_level, rx_level;
  logic          rx_overrun, rx_frame_err;

  uart_fifo_port_if bus();
  assign rxd = loop ? txd : tb_rxd;

  uart_fifo_port #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus), .rxd(rxd), .txd(txd),
    .tx_level(tx_level), .rx_level(rx_level),
    .rx_overrun(rx_overrun), .rx_frame_err(rx_frame_err), .clr_err_in(clr_err));

  int n_cmp = 0, n_bad = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // all tasks are entered and left at a negedge
  task automatic push_tx(input logic [7:0] b);
    bus.tx_data_in = b; bus.tx_we_in = 1'b1;
    @(negedge clk);
    bus.tx_we_in = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    int e;
    chk({tag, "_v"}, 32'(bus.rx_valid_out), 32'd1);
    if (exp_q.size() != 0) e = int'(exp_q.pop_front());
    else                   e = -1;
    chk(tag, 32'(bus.rx_data_out), e);
    bus.rx_re_in = 1'b1;
    @(negedge clk);
    bus.rx_re_in = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stopb);
    tb_rxd = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rxd = b[i];
      repeat (BITC) @(negedge clk);
    end
    tb_rxd = stopb;
    repeat (BITC) @(negedge clk);
    tb_rxd = 1'b1;
  endtask

  task automatic wait_txd_low(input string tag);
    int n;
    for (n = 0; n < 100 && txd; n++) @(negedge clk);
    chk(tag, 32'(txd), 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int lim);
    int n;
    for (n = 0; n < lim && !bus.rx_valid_out; n++) @(negedge clk);
    chk(tag, 32'(bus.rx_valid_out), 32'd1);
  endtask

  initial begin
    logic [9:0] fr;
    int n, lows;
    rst = 1'b0; loop = 1'b0; tb_rxd = 1'b1; clr_err = 1'b0;
    bus.tx_data_in = '0; bus.tx_we_in = 1'b0; bus.rx_re_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_txd",   32'(txd), 32'd1);
    chk("rst_busy",  32'(bus.tx_busy_out), 32'd0);
    chk("rst_valid", 32'(bus.rx_valid_out), 32'd0);
    chk("rst_data",  32'(bus.rx_data_out), 32'd0);
    chk("rst_lvls",  32'({tx_level, rx_level}), 32'd0);
    chk("rst_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // 1: frame timing of 0x55, every bit exactly BITC clocks
    push_tx(8'h55);
    wait_txd_low("t1_start");
    chk("t1_lvl0", 32'(tx_level), 32'd0);
    fr = {1'b1, 8'h55, 1'b0};
    for (int c = 0; c < 10 * BITC; c++) begin
      if ((c % BITC == 0) || (c % BITC == BITC - 1))
        chk($sformatf("t1_bit%0d_c%0d", c / BITC, c), 32'(txd), 32'(fr[c / BITC]));
      @(negedge clk);
    end
    repeat (200) @(negedge clk);
    chk("t1_idle", 32'(txd), 32'd1);

    // 2: loopback of two back-to-back bytes
    loop = 1'b1;
    push_tx(8'hA3); exp_q.push_back(8'hA3);
    push_tx(8'h0F); exp_q.push_back(8'h0F);
    wait_valid("t2_valid", 4000);
    chk("t2_first", 32'(bus.rx_data_out), 32'(exp_q[0]));
    for (n = 0; n < 2500 && rx_level != 5'd2; n++) @(negedge clk);
    chk("t2_lvl2", 32'(rx_level), 32'd2);
    pop_check("t2_pop0");
    pop_check("t2_pop1");
    chk("t2_empty_v", 32'(bus.rx_valid_out), 32'd0);
    chk("t2_empty_d", 32'(bus.rx_data_out), 32'd0);
    chk("t2_ferr",    32'(rx_frame_err), 32'd0);
    repeat (200) @(negedge clk);

    // 3: TX FIFO fills while the line is busy with 0xEE
    push_tx(8'hEE); exp_q.push_back(8'hEE);
    wait_txd_low("t3_line_busy");
    for (int i = 0; i < 17; i++) begin
      push_tx(8'(i));
      if (i < 16) exp_q.push_back(8'(i));
      chk($sformatf("t3_busy%0d", i), 32'(bus.tx_busy_out), 32'(i >= 15));
      chk($sformatf("t3_lvl%0d", i),  32'(tx_level), (i < 16) ? 32'(i + 1) : 32'd16);
    end
    for (int k = 0; k < 17; k++) begin
      wait_valid($sformatf("t3_wait%0d", k), 2000);
      pop_check($sformatf("t3_rx%0d", k));
    end
    chk("t3_tx_empty", 32'(tx_level), 32'd0);
    chk("t3_rx_empty", 32'(bus.rx_valid_out), 32'd0);
    chk("t3_no_ovr",   32'(rx_overrun), 32'd0);
    repeat (200) @(negedge clk);

    // 4: RX overrun, then clear
    loop = 1'b0;
    for (int b = 1; b <= 17; b++) begin
      if (b <= DEPTH) exp_q.push_back(8'(b));
      send_rx(8'(b), 1'b1);
    end
    repeat (40) @(negedge clk);
    chk("t4_lvl",  32'(rx_level), 32'd16);
    chk("t4_head", 32'(bus.rx_data_out), 32'(exp_q[0]));
    chk("t4_ovr",  32'(rx_overrun), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t4_ovr_clr",  32'(rx_overrun), 32'd0);
    chk("t4_lvl_kept", 32'(rx_level), 32'd16);
    for (int k = 0; k < DEPTH; k++) pop_check($sformatf("t4_rx%0d", k));
    chk("t4_empty_v", 32'(bus.rx_valid_out), 32'd0);
    chk("t4_empty_d", 32'(bus.rx_data_out), 32'd0);

    // 5: framing error, then a short glitch, then a clean byte
    send_rx(8'h7E, 1'b0);
    repeat (2 * BITC) @(negedge clk);
    chk("t5_nopush", 32'(rx_level), 32'd0);
    chk("t5_ferr",   32'(rx_frame_err), 32'd1);
    tb_rxd = 1'b0;
    repeat (40) @(negedge clk);
    tb_rxd = 1'b1;
    repeat (400) @(negedge clk);
    chk("t5_glitch_lvl", 32'(rx_level), 32'd0);
    chk("t5_glitch_v",   32'(bus.rx_valid_out), 32'd0);
    exp_q.push_back(8'h5A);
    send_rx(8'h5A, 1'b1);
    repeat (40) @(negedge clk);
    pop_check("t5_after_glitch");

    // 6: asynchronous reset in DATA bit 3 of 0x11 (bit value 0)
    push_tx(8'h11); push_tx(8'h22); push_tx(8'h33);
    wait_txd_low("t6_start");
    repeat (4 * BITC + 80) @(negedge clk);
    chk("t6_pre_txd", 32'(txd), 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("t6_txd_async", 32'(txd), 32'd1);
    chk("t6_lvls",  32'({tx_level, rx_level}), 32'd0);
    chk("t6_flags", 32'({rx_overrun, rx_frame_err}), 32'd0);
    chk("t6_busy",  32'(bus.tx_busy_out), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    lows = 0;
    repeat (5000) begin
      @(negedge clk);
      if (!txd) lows++;
    end
    chk("t6_no_residual", 32'(lows), 32'd0);
    chk("t6_tx_lvl",      32'(tx_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_fifo_port.md
Name: uart_fifo_port

Overview:
- Complete UART peripheral sitting directly downstream of the pipelined data path's MMIO UART signals.
- Consumes tx byte strobes from `sw 0x1000_0000` and produces rx data/valid and tx busy for `lw 0x1000_0000` / `lw 0x1000_0004`.
- Contains a TX FIFO, an RX FIFO, a 16x-oversampling baud generator, and TX/RX serial state machines.
- Line format is fixed at 8N1, LSB first.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate; oversample tick divider DIV = CLK_HZ/(16*BAUD), integer-truncated, minimum 1
FIFO_DEPTH, 16, entries per FIFO; power of two, >= 2
LW, $clog2(FIFO_DEPTH)+1, level-counter width (derived, not overridable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
tx_data_in  in  8  byte to transmit
tx_we_in  in  1  single-cycle push strobe into TX FIFO
tx_busy_out  out  1  TX FIFO full
rx_data_out  out  8  RX FIFO head (first-word-fall-through); 0 when empty
rx_valid_out  out  1  RX FIFO non-empty
rx_re_in  in  1  single-cycle pop strobe from RX FIFO
rxd  in  1  serial input, asynchronous to clk
txd  out  1  serial output, idle high
tx_level  out  LW  TX FIFO occupancy
rx_level  out  LW  RX FIFO occupancy
rx_overrun  out  1  sticky: byte dropped because RX FIFO was full
rx_frame_err  out  1  sticky: stop bit sampled low
clr_err_in  in  1  clears both sticky flags

Behaviour:
- Reset (rst low, asynchronous):
  - txd=1; tx_busy_out=0; rx_valid_out=0; rx_data_out=0; levels=0; flags=0.
  - FIFO pointers=0; both FSMs IDLE; tick counter=0; rxd synchronizer=2'b11.
  - Reset mid-frame aborts the frame immediately and discards FIFO contents.
- Baud tick:
  - Free-running counter 0..DIV-1; `tick` is asserted for one cycle when the counter wraps.
  - One bit = 16 ticks.
- TX FIFO push:
  - Accepted when tx_we_in=1 and not full.
  - A push while full is silently dropped; contents unchanged.
  - Push and FSM pop in the same cycle: both occur; level unchanged.
  - tx_busy_out = (tx_level==FIFO_DEPTH), registered through the level counter; it updates the cycle after the push.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on the first tick with the FIFO non-empty, pop the head into the shift register and go to START with txd=0.
  - START: 16 ticks, then DATA.
  - DATA: 8 bits LSB first, 16 ticks each.
  - STOP: txd=1 for 16 ticks, then IDLE.
  - Back-to-back bytes: no extra idle beyond waiting for the next tick.
- RX synchronizer: rxd passes through 2 flip-flops before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a tick with synchronized rxd=0, go to START with sample counter=0.
  - START: at tick count 7 (mid-bit), if rxd=1 treat it as a glitch and return to IDLE; else continue, realigning bit sampling to tick 7 of each subsequent bit.
  - DATA: sample 8 bits mid-bit, LSB first.
  - STOP: sample mid-bit.
    - rxd=1: push the byte if the RX FIFO is not full; if full, drop the byte and set rx_overrun.
    - rxd=0: discard the byte and set rx_frame_err.
  - After the STOP sample, return to IDLE.
- RX FIFO pop:
  - rx_re_in=1 while non-empty advances the head.
  - rx_re_in while empty is ignored.
  - Simultaneous push and pop: both occur.
  - rx_data_out reflects the new head the cycle after a pop.
- Flag clearing: clr_err_in clears the flags; if a set event occurs in the same cycle, set wins.
- Pointers: wrap modulo FIFO_DEPTH. Levels are exact (0..FIFO_DEPTH), never wrap.

Test Plan:
1. Frame timing. Setup: CLK_HZ=1600000, BAUD=10000 (DIV=10, 160 cycles/bit). Stimulus: push 0x55 once. Required: txd low-time sequence start0,1,0,1,0,1,0,1,0,stop1, each bit exactly 160 cycles; tx_level returns to 0 at start bit; txd=1 afterwards.
2. Loopback. Stimulus: txd tied to rxd; push 0xA3 then 0x0F back-to-back. Required: rx_valid_out rises after frame 1 stop sample with rx_data_out=0xA3; after one rx_re_in, rx_data_out=0x0F; after a second pop, rx_valid_out=0 and rx_data_out=0; rx_frame_err=0.
3. TX full. Stimulus: 17 consecutive tx_we_in pulses of 0x00..0x10 while the line is busy. Required: tx_busy_out=1 after the 16th accepted push (tx_level=16, or 15 if the first byte was already popped); 0x10 is dropped; the serial stream carries 0x00..0x0F only.
4. RX overrun and clear. Stimulus: 17 bytes 0x01..0x11 on rxd without reading. Required: rx_level=16, head=0x01, rx_overrun=1. Stimulus: clr_err_in pulse. Required: rx_overrun=0, FIFO intact.
5. Framing error and glitch. Stimulus: byte 0x7E with stop bit driven 0. Required: no push, rx_frame_err=1. Stimulus: rxd low for 4 ticks only. Required: no frame started, rx_level unchanged.
6. Reset mid-frame. Stimulus: rst low during DATA bit 3 of TX with 3 bytes queued. Required: txd=1 asynchronously; tx_level=0, rx_level=0, flags=0. After release, no residual bytes are transmitted.
